// File: rtl/wb_commit_if.sv
// Commit-trace handshake between the writeback stage
// and the debug host that drains retired (pc, inst) pairs.
interface wb_commit_if;
  logic        trace_valid;
  logic        i_trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;

  modport master (
    output trace_valid,
    output trace_pc,
    output trace_inst,
    input  i_trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_pc,
    input  trace_inst,
    output i_trace_ready
  );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit stage: regfile write, bypassed read ports,
// retire counter and a small commit-trace FIFO for the debug host.
module wb_commit #(
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned CNT_W       = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [31:0]      i_mem_out,
  input  logic [31:0]      i_alu_out,
  input  logic [4:0]       i_rd_num,
  input  logic             i_op_type,
  input  logic             i_reg_write,
  input  logic [31:0]      i_debug_pc,
  input  logic [31:0]      i_debug_inst,
  input  logic [4:0]       i_rs1_num,
  input  logic [4:0]       i_rs2_num,
  output logic [31:0]      rs1_data,
  output logic [31:0]      rs2_data,
  output logic [31:0]      wb_data,
  output logic             wb_en,
  output logic [CNT_W-1:0] instret,
  wb_commit_if.master      trace,
  output logic             trace_overflow
);

  localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } trace_ent_t;

  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic [CNT_W-1:0] instret_q, instret_d;

  trace_ent_t       mem_q [TRACE_DEPTH];
  trace_ent_t       mem_d [TRACE_DEPTH];
  trace_ent_t       last_q, last_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             full;
  logic             not_empty;
  logic             push;
  logic             pop;
  trace_ent_t       head;

  // Writeback value select and write qualification.
  always_comb begin
    wb_data = i_op_type ? i_mem_out : i_alu_out;
    wb_en   = i_valid & i_reg_write & (i_rd_num != 5'd0);
  end

  // Read port 1: x0 is hardwired, same-cycle write wins.
  always_comb begin
    rs1_data = '0;
    if (i_rs1_num != 5'd0) begin
      if (wb_en && (i_rd_num == i_rs1_num)) rs1_data = wb_data;
      else                                  rs1_data = regs_q[i_rs1_num];
    end
  end

  // Read port 2: same rules as port 1, fully independent.
  always_comb begin
    rs2_data = '0;
    if (i_rs2_num != 5'd0) begin
      if (wb_en && (i_rd_num == i_rs2_num)) rs2_data = wb_data;
      else                                  rs2_data = regs_q[i_rs2_num];
    end
  end

  // Next register file and retire count.
  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[i_rd_num] = wb_data;
    instret_d = instret_q + CNT_W'(i_valid);
  end

  // Trace FIFO status and handshake qualification.
  always_comb begin
    full      = (cnt_q == CW'(TRACE_DEPTH));
    not_empty = (cnt_q != '0);
    pop       = not_empty & trace.i_trace_ready;
    push      = i_valid & (~full | pop);
    head      = not_empty ? mem_q[rd_q] : last_q;
  end

  // Trace FIFO next state; a dropped commit makes overflow sticky.
  always_comb begin
    mem_d  = mem_q;
    last_d = last_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ovf_d  = ovf_q | (i_valid & ~push);
    if (push) begin
      mem_d[wr_q] = '{pc: i_debug_pc, inst: i_debug_inst};
      wr_d        = wr_q + PW'(1);
    end
    if (pop) begin
      last_d = mem_q[rd_q];
      rd_d   = rd_q + PW'(1);
    end
  end

  // State registers; reset clears everything and beats any commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      for (int i = 0; i < int'(TRACE_DEPTH); i++) mem_q[i] <= '0;
      instret_q <= '0;
      last_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      mem_q     <= mem_d;
      instret_q <= instret_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Output mapping.
  always_comb begin
    instret           = instret_q;
    trace_overflow    = ovf_q;
    trace.trace_valid = not_empty;
    trace.trace_pc    = head.pc;
    trace.trace_inst  = head.inst;
  end

endmodule

// File: tb/tb_wb_commit.sv
// Randomized + directed bench for wb_commit against a
// queue-based reference model of the commit stage.
module tb_wb_commit;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_mem_out, i_alu_out;
  logic [4:0]  i_rd_num;
  logic        i_op_type, i_reg_write;
  logic [31:0] i_debug_pc, i_debug_inst;
  logic [4:0]  i_rs1_num, i_rs2_num;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_en;
  logic [63:0] instret;
  logic        trace_overflow;

  wb_commit_if tif ();

  wb_commit #(.TRACE_DEPTH(D), .CNT_W(64)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .i_mem_out      (i_mem_out),
    .i_alu_out      (i_alu_out),
    .i_rd_num       (i_rd_num),
    .i_op_type      (i_op_type),
    .i_reg_write    (i_reg_write),
    .i_debug_pc     (i_debug_pc),
    .i_debug_inst   (i_debug_inst),
    .i_rs1_num      (i_rs1_num),
    .i_rs2_num      (i_rs2_num),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .wb_data        (wb_data),
    .wb_en          (wb_en),
    .instret        (instret),
    .trace          (tif),
    .trace_overflow (trace_overflow)
  );

  always #5 clk = ~clk;

  // reference model
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  logic [63:0] m_q [$];
  logic [63:0] m_last;
  logic        m_ovf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_instret = '0;
    m_q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a,
      input logic wen, input logic [4:0] rd, input logic [31:0] d);
    if (a == 0) return 32'h0;
    if (wen && rd == a) return d;
    return m_regs[a];
  endfunction

  // drive one cycle, check combinational + state outputs, clock, update model
  task automatic step(input logic v, input logic [31:0] mo,
      input logic [31:0] ao, input logic [4:0] rd, input logic op,
      input logic rw, input logic [31:0] pc, input logic [31:0] inst,
      input logic [4:0] a1, input logic [4:0] a2, input logic rdy,
      input logic rst);
    logic [31:0] e_d;
    logic        e_en;
    logic [63:0] e_head;
    logic        pop, push;
    i_valid = v; i_mem_out = mo; i_alu_out = ao; i_rd_num = rd;
    i_op_type = op; i_reg_write = rw; i_debug_pc = pc;
    i_debug_inst = inst; i_rs1_num = a1; i_rs2_num = a2;
    tif.i_trace_ready = rdy; i_rst = rst;
    #1;
    e_d    = op ? mo : ao;
    e_en   = v && rw && rd != 0;
    e_head = (m_q.size() > 0) ? m_q[0] : m_last;
    chk("wb_data", {32'h0, wb_data}, {32'h0, e_d});
    chk("wb_en", {63'h0, wb_en}, {63'h0, e_en});
    chk("rs1", {32'h0, rs1_data}, {32'h0, exp_rd(a1, e_en, rd, e_d)});
    chk("rs2", {32'h0, rs2_data}, {32'h0, exp_rd(a2, e_en, rd, e_d)});
    chk("instret", instret, m_instret);
    chk("tvalid", {63'h0, tif.trace_valid}, {63'h0, m_q.size() > 0});
    chk("tpc", {32'h0, tif.trace_pc}, {32'h0, e_head[63:32]});
    chk("tinst", {32'h0, tif.trace_inst}, {32'h0, e_head[31:0]});
    chk("ovf", {63'h0, trace_overflow}, {63'h0, m_ovf});
    @(posedge clk);
    if (rst) model_reset();
    else begin
      pop  = (m_q.size() > 0) && rdy;
      push = v && ((m_q.size() < D) || pop);
      if (pop) m_last = m_q.pop_front();
      if (push) m_q.push_back({pc, inst});
      if (v && !push) m_ovf = 1'b1;
      if (e_en) m_regs[rd] = e_d;
      if (v) m_instret = m_instret + 64'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic commit(input logic [31:0] pc, input logic rdy);
    step(1, $urandom, $urandom, 5'($urandom_range(1, 31)), 0, 1,
         pc, $urandom, 0, 0, rdy, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 0; i_mem_out = 0; i_alu_out = 0;
    i_rd_num = 0; i_op_type = 0; i_reg_write = 0; i_debug_pc = 0;
    i_debug_inst = 0; i_rs1_num = 0; i_rs2_num = 0;
    tif.i_trace_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    i_rst = 1'b0;
    #1;
    chk("rst_instret", instret, 64'h0);
    chk("rst_tvalid", {63'h0, tif.trace_valid}, 64'h0);
    chk("rst_tpc", {32'h0, tif.trace_pc}, 64'h0);
    chk("rst_ovf", {63'h0, trace_overflow}, 64'h0);
    @(negedge clk);

    // load commit with bypass, then storage read
    step(1, 32'hDEADBEEF, 32'h1, 5, 1, 1, 32'h0, 32'h13, 5, 0, 0, 0);
    chk("ld_instret", instret, 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0);
    chk("ld_stored", {32'h0, rs1_data}, 64'hDEADBEEF);
    // write to x0
    step(1, 0, 32'h1234, 0, 0, 1, 32'h4, 32'h13, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // bubble, then non-writing commit
    step(0, 0, 32'h55, 3, 0, 1, 32'h8, 32'h13, 3, 3, 0, 0);
    step(1, 0, 32'h66, 3, 0, 0, 32'h8, 32'h23, 3, 3, 0, 0);
    chk("st_instret", instret, 64'd3);

    // fill to full, overflow on 9th, drain in order
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) commit(32'(i * 4), 0);
    chk("full_noovf", {63'h0, trace_overflow}, 64'h0);
    step(1, 0, 32'hABCD, 7, 0, 1, 32'h20, 32'h1, 0, 0, 0, 0);
    chk("ovf_set", {63'h0, trace_overflow}, 64'h1);
    chk("ovf_instret", instret, 64'd9);
    for (int i = 0; i < 8; i++) begin
      chk("drain_pc", {32'h0, tif.trace_pc}, 64'(i * 4));
      idle(1);
    end
    chk("drained", {63'h0, tif.trace_valid}, 64'h0);
    chk("hold_pc", {32'h0, tif.trace_pc}, 64'h1C);

    // full with simultaneous push+pop
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) commit(32'h100 + 32'(i * 4), 0);
    commit(32'h40, 1);
    chk("pp_noovf", {63'h0, trace_overflow}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      chk("pp_valid", {63'h0, tif.trace_valid}, 64'h1);
      idle(1);
    end
    chk("pp_last", {32'h0, tif.trace_pc}, 64'h40);

    // reset mid-operation
    for (int i = 0; i < 3; i++) commit(32'h200 + 32'(i * 4), 0);
    step(1, 0, 32'h77, 9, 0, 1, 32'h300, 32'h1, 9, 0, 1, 1);
    chk("mr_tvalid", {63'h0, tif.trace_valid}, 64'h0);
    chk("mr_instret", instret, 64'h0);
    for (int k = 0; k < 16; k++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 5'(k), 5'(31 - k), 0, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] rd, a1, a2;
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, $urandom, $urandom, rd,
           1'($urandom), $urandom_range(0, 3) != 0, $urandom, $urandom,
           a1, a2, $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Writeback/commit stage at the consumer end of the MEM/WB pipeline register in the RISC-V core.
- Takes the latched MEM/WB bundle (mem_out, alu_out, rd_num, op_type, debug pc/inst) and selects the writeback value.
- Writes the 32x32 integer register file, which the decode stage reads through two ports with same-cycle write bypass.
- Counts retired instructions and pushes a commit trace (pc, inst) into a small FIFO, which a debug host drains via valid/ready.

Parameters:
- TRACE_DEPTH, 8, trace FIFO entries; power of two, at least 2.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- i_clk  input  1  core clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  MEM/WB bundle holds a real instruction (0 = bubble).
- i_mem_out  input  32  load data from MEM/WB.
- i_alu_out  input  32  ALU result from MEM/WB.
- i_rd_num  input  5  destination register number.
- i_op_type  input  1  1 = load (write i_mem_out), 0 = ALU (write i_alu_out).
- i_reg_write  input  1  instruction writes rd (0 for stores/branches).
- i_debug_pc  input  32  pc of the committing instruction.
- i_debug_inst  input  32  encoding of the committing instruction.
- i_rs1_num  input  5  decode read port 1 address.
- i_rs2_num  input  5  decode read port 2 address.
- rs1_data  output  32  read port 1 data.
- rs2_data  output  32  read port 2 data.
- wb_data  output  32  selected writeback value (combinational; used for forwarding).
- wb_en  output  1  register write occurring this cycle.
- instret  output  CNT_W  retired-instruction count.
- trace_valid  output  1  trace FIFO non-empty.
- i_trace_ready  input  1  host accepts the head entry this cycle.
- trace_pc  output  32  head entry pc.
- trace_inst  output  32  head entry instruction.
- trace_overflow  output  1  sticky flag; a commit was dropped because the FIFO was full.

Behaviour:
- Reset: i_rst sampled at the clock edge. On reset all 32 registers are set to 0, instret is 0, the FIFO is emptied (trace_valid 0, trace_pc/trace_inst read 0), and trace_overflow is 0. Reset overrides any commit, push or pop in the same cycle. A reset mid-drain discards all entries.
- Writeback select:
  - wb_data = i_op_type ? i_mem_out : i_alu_out, combinational.
  - wb_en = i_valid & i_reg_write & (i_rd_num != 0).
- Register write: when wb_en is 1, regs[i_rd_num] <= wb_data at the edge. Register x0 is never written and always reads 0.
- Read ports are combinational:
  - If the read address is 0, output 0.
  - Else if wb_en is 1 and i_rd_num equals the read address, output wb_data (write-first bypass, zero latency).
  - Otherwise output the stored register.
  - Both ports are independent and may alias each other or rd.
- Retire counter: instret increments by 1 on every cycle with i_valid=1, whether or not the instruction writes a register. It wraps modulo 2^CNT_W with no flag.
- Trace FIFO:
  - push = i_valid & (not full or pop).
  - pop = trace_valid & i_trace_ready.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Full with simultaneous pop: the push is accepted.
  - Full without pop: the commit is dropped from the trace only (the register write and instret still occur) and trace_overflow is set until reset.
  - Empty: pop is ignored and the head outputs hold their last value.
  - Pointers wrap modulo TRACE_DEPTH; the count is kept separately so full and empty are unambiguous.
- Latency:
  - A pushed entry becomes visible on trace_valid the cycle after the push (registered occupancy).
  - Order is strictly FIFO.
- Bubbles (i_valid=0): no write, no count, no push, regardless of other inputs.

Test Plan:
- Reset, then load commit: i_valid=1, i_reg_write=1, op_type=1, rd=5, mem_out=0xDEADBEEF, alu_out=0x1 -> wb_data=0xDEADBEEF; with rs1=5 the same cycle rs1_data=0xDEADBEEF (bypass); next cycle rs1_data from storage = 0xDEADBEEF; instret=1.
- Write to x0: rd=0, alu_out=0x1234, op_type=0 -> wb_en=0; reading rs1=0 and rs2=0 gives 0 in the same cycle and the next; instret still increments.
- Bubble and store: i_valid=0 with rd=3 and reg_write=1 -> x3 unchanged, instret unchanged, no trace entry. i_valid=1, reg_write=0 -> no write, instret+1, trace entry pushed.
- FIFO fill/overflow, i_trace_ready=0:
  - 8 commits at pc 0x0..0x1C, then a 9th at pc 0x20 -> trace_overflow=1, register write and instret still occur.
  - Drain with i_trace_ready=1 -> pcs 0x0..0x1C in order; 0x20 never appears.
- Full with simultaneous push+pop: FIFO full, i_trace_ready=1 and commit at pc 0x40 in the same cycle -> head pops, 0x40 enqueued, occupancy stays 8, no overflow.
- Reset mid-operation: assert i_rst with 3 entries queued and a commit present -> next cycle trace_valid=0, instret=0, all registers read 0, the commit ignored.
